// File: rtl/conv_job_scheduler_if.sv
// rtl/conv_job_scheduler_if.sv - host command channel, engine handshake and relocated memory address bundle
interface conv_job_scheduler_if #(
    parameter int ADDR_W = 12
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_in_base;
    logic [ADDR_W-1:0] cmd_out_base;
    logic [ADDR_W-1:0] cmd_wgt_base;
    logic              eng_run;
    logic              eng_busy;
    logic [ADDR_W-1:0] eng_rd_addr;
    logic [ADDR_W-1:0] eng_wr_addr;
    logic [ADDR_W-1:0] eng_wmem_addr;
    logic [ADDR_W-1:0] sram_rd_addr;
    logic [ADDR_W-1:0] sram_wr_addr;
    logic [ADDR_W-1:0] wmem_rd_addr;

    modport slave (
        input  cmd_valid, cmd_in_base, cmd_out_base, cmd_wgt_base,
        input  eng_busy, eng_rd_addr, eng_wr_addr, eng_wmem_addr,
        output cmd_ready, eng_run, sram_rd_addr, sram_wr_addr, wmem_rd_addr
    );

    modport master (
        output cmd_valid, cmd_in_base, cmd_out_base, cmd_wgt_base,
        output eng_busy, eng_rd_addr, eng_wr_addr, eng_wmem_addr,
        input  cmd_ready, eng_run, sram_rd_addr, sram_wr_addr, wmem_rd_addr
    );
endinterface

// File: rtl/conv_job_scheduler.sv
// rtl/conv_job_scheduler.sv - queues conv jobs, launches the engine and relocates its memory addresses
module conv_job_scheduler #(
    parameter int FIFO_DEPTH    = 4,
    parameter int ADDR_W        = 12,
    parameter int START_TIMEOUT = 8,
    parameter int CNT_W         = 8
) (
    input  logic                     clk,
    input  logic                     reset_b,
    conv_job_scheduler_if.slave      bus,
    output logic                     job_done,
    output logic [CNT_W-1:0]         jobs_completed,
    output logic                     start_err,
    input  logic                     err_clr,
    output logic                     sched_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(START_TIMEOUT + 1);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, RUN, DONE} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] in_base;
        logic [ADDR_W-1:0] out_base;
        logic [ADDR_W-1:0] wgt_base;
    } job_t;

    job_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    state_t           state_q, state_d;
    job_t             active_q, active_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             eng_run_q, eng_run_d;
    logic             job_done_q, job_done_d;
    logic [CNT_W-1:0] jobs_q, jobs_d;
    logic             start_err_q, start_err_d;
    logic             full, empty, push, pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = bus.cmd_valid & ~full;
    assign pop   = (state_q == IDLE) & ~empty;

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{bus.cmd_in_base, bus.cmd_out_base, bus.cmd_wgt_base};
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        timer_d     = timer_q;
        eng_run_d   = 1'b0;
        job_done_d  = 1'b0;
        jobs_d      = jobs_q;
        start_err_d = start_err_q & ~err_clr;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    active_d = fifo_mem[rd_ptr_q];
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_run_d = 1'b1;
                timer_d   = '0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                if (bus.eng_busy) begin
                    state_d = RUN;
                end else if (timer_q == TMR_LAST) begin
                    // A timeout set overrides a simultaneous clear.
                    start_err_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RUN: begin
                if (!bus.eng_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                job_done_d = 1'b1;
                if (jobs_q != '1) begin
                    jobs_d = jobs_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            active_q    <= '0;
            timer_q     <= '0;
            eng_run_q   <= 1'b0;
            job_done_q  <= 1'b0;
            jobs_q      <= '0;
            start_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            active_q    <= active_d;
            timer_q     <= timer_d;
            eng_run_q   <= eng_run_d;
            job_done_q  <= job_done_d;
            jobs_q      <= jobs_d;
            start_err_q <= start_err_d;
        end
    end

    assign bus.cmd_ready    = ~full;
    assign bus.eng_run      = eng_run_q;
    assign bus.sram_rd_addr = active_q.in_base  + bus.eng_rd_addr;
    assign bus.sram_wr_addr = active_q.out_base + bus.eng_wr_addr;
    assign bus.wmem_rd_addr = active_q.wgt_base + bus.eng_wmem_addr;

    assign job_done       = job_done_q;
    assign jobs_completed = jobs_q;
    assign start_err      = start_err_q;
    assign sched_busy     = (state_q != IDLE) | ~empty;
endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb/tb_conv_job_scheduler.sv - self-checking bench for conv_job_scheduler with an engine model and job scoreboard
module tb_conv_job_scheduler;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_b, err_clr, cmd_valid, eng_busy;
    logic [AW-1:0] cin, cout, cwgt;
    logic [AW-1:0] loc_rd, loc_wr, loc_wm, fix_rd, fix_wr, fix_wm;
    logic          job_done0, job_done1, start_err0, start_err1, sched_busy0, sched_busy1;
    logic [7:0]    jobs0;
    logic [1:0]    jobs1;

    conv_job_scheduler_if #(.ADDR_W(AW)) if0 ();
    conv_job_scheduler_if #(.ADDR_W(AW)) if1 ();

    assign if0.cmd_valid = cmd_valid;  assign if1.cmd_valid = cmd_valid;
    assign if0.cmd_in_base = cin;      assign if1.cmd_in_base = cin;
    assign if0.cmd_out_base = cout;    assign if1.cmd_out_base = cout;
    assign if0.cmd_wgt_base = cwgt;    assign if1.cmd_wgt_base = cwgt;
    assign if0.eng_busy = eng_busy;    assign if1.eng_busy = eng_busy;
    assign if0.eng_rd_addr = loc_rd;   assign if1.eng_rd_addr = loc_rd;
    assign if0.eng_wr_addr = loc_wr;   assign if1.eng_wr_addr = loc_wr;
    assign if0.eng_wmem_addr = loc_wm; assign if1.eng_wmem_addr = loc_wm;

    conv_job_scheduler #(.FIFO_DEPTH(4), .ADDR_W(AW), .START_TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .reset_b(reset_b), .bus(if0), .job_done(job_done0),
        .jobs_completed(jobs0), .start_err(start_err0), .err_clr(err_clr), .sched_busy(sched_busy0));

    conv_job_scheduler #(.FIFO_DEPTH(4), .ADDR_W(AW), .START_TIMEOUT(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_b(reset_b), .bus(if1), .job_done(job_done1),
        .jobs_completed(jobs1), .start_err(start_err1), .err_clr(err_clr), .sched_busy(sched_busy1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { logic [AW-1:0] in_b, out_b, wgt_b; } job_t;
    job_t exp_q[$];
    job_t cur;
    bit   cur_v = 0;
    int   launches = 0, pulses0 = 0, pulses1 = 0;

    // Engine model: busy rises eng_delay cycles after eng_run and lasts eng_hold cycles.
    bit rand_eng = 0, eng_stall = 0, eng_never = 0, rand_addr = 0;
    int eng_delay = 2, eng_hold = 40, cur_delay, cur_hold, ecnt, eph, model_done;
    always @(posedge clk) begin
        if (!reset_b) begin
            eph <= 0; eng_busy <= 1'b0; model_done <= 0;
        end else begin
            case (eph)
                0: if (if0.eng_run && !eng_never) begin
                       eph <= 1; ecnt <= 1;
                       cur_delay <= rand_eng ? int'($urandom_range(2, 6)) : eng_delay;
                       cur_hold  <= rand_eng ? int'($urandom_range(1, 10)) : eng_hold;
                   end
                1: if (ecnt >= cur_delay - 1) begin
                       eng_busy <= 1'b1; eph <= 2; ecnt <= 1;
                   end else ecnt <= ecnt + 1;
                default: if (ecnt >= cur_hold && !eng_stall) begin
                       eng_busy <= 1'b0; eph <= 0; model_done <= model_done + 1;
                   end else ecnt <= ecnt + 1;
            endcase
        end
    end

    always @(posedge clk) begin
        #2;
        if (rand_addr) begin
            loc_rd = AW'($urandom); loc_wr = AW'($urandom); loc_wm = AW'($urandom);
        end else begin
            loc_rd = fix_rd; loc_wr = fix_wr; loc_wm = fix_wm;
        end
    end

    // Scoreboard: each launch takes the oldest accepted job; relocation is checked while busy.
    always @(negedge clk) begin
        logic [AW-1:0] e_rd, e_wr, e_wm;
        if (!reset_b) begin
            exp_q.delete(); cur_v = 0; pulses0 = 0; pulses1 = 0;
        end else begin
            if (if0.eng_run) begin
                launches++;
                chk("launch_has_job", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin cur = exp_q.pop_front(); cur_v = 1; end
            end
            if (eng_busy && cur_v) begin
                e_rd = cur.in_b + loc_rd; e_wr = cur.out_b + loc_wr; e_wm = cur.wgt_b + loc_wm;
                chk("reloc_rd", if0.sram_rd_addr, e_rd);
                chk("reloc_wr", if0.sram_wr_addr, e_wr);
                chk("reloc_wm", if0.wmem_rd_addr, e_wm);
            end
            if (job_done0) pulses0++;
            if (job_done1) pulses1++;
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
        int t = 0;
        job_t j;
        @(negedge clk);
        cmd_valid = 1'b1; cin = a; cout = b; cwgt = c;
        while (!if0.cmd_ready && t < 400) begin @(negedge clk); t++; end
        chk("push_accept_timeout", t < 400, 1);
        j.in_b = a; j.out_b = b; j.wgt_b = c;
        exp_q.push_back(j);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_busy();
        int t = 0;
        while (!eng_busy && t < 100) begin @(negedge clk); t++; end
        chk("wait_busy_timeout", t < 100, 1);
    endtask

    task automatic wait_run();
        int t = 0;
        do begin @(negedge clk); t++; end while (!if0.eng_run && t < 100);
        chk("wait_run_timeout", t < 100, 1);
    endtask

    task automatic wait_done();
        int t = 0;
        do begin @(negedge clk); t++; end while (!job_done0 && t < 200);
        chk("wait_done_timeout", t < 200, 1);
    endtask

    task automatic wait_idle(input int lim);
        int t = 0;
        while ((sched_busy0 || eng_busy) && t < lim) begin @(negedge clk); t++; end
        chk("wait_idle_timeout", t < lim, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_jobs"}, jobs0, (model_done > 255) ? 255 : model_done);
        chk({tag, "_pulses"}, pulses0, model_done);
        chk({tag, "_jobs_sat"}, jobs1, (model_done > 3) ? 3 : model_done);
        chk({tag, "_pulses_sat"}, pulses1, model_done);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset_b = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #3 reset_b = 1'b1;
    endtask

    typedef struct {
        logic [AW-1:0] in_b, out_b, wgt_b, rd, wr, wm, e_rd, e_wr, e_wm;
    } vec_t;
    vec_t vt[4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv;
        vt[0] = '{12'h100, 12'h200, 12'h010, 12'h005, 12'h007, 12'h001, 12'h105, 12'h207, 12'h011};
        vt[1] = '{12'hFF0, 12'h800, 12'hFFF, 12'h020, 12'h900, 12'h002, 12'h010, 12'h100, 12'h001};
        vt[2] = '{12'h000, 12'hABC, 12'h123, 12'h0FF, 12'h001, 12'hEDC, 12'h0FF, 12'hABD, 12'hFFF};
        vt[3] = '{12'h7FF, 12'h001, 12'h800, 12'h001, 12'hFFF, 12'h800, 12'h800, 12'h000, 12'h000};

        reset_b = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0;
        cin = '0; cout = '0; cwgt = '0;
        fix_rd = 12'h5A5; fix_wr = 12'h3C3; fix_wm = 12'h0F0;
        repeat (3) @(negedge clk);
        chk("rst_eng_run", if0.eng_run, 0);
        chk("rst_job_done", job_done0, 0);
        chk("rst_jobs", jobs0, 0);
        chk("rst_start_err", start_err0, 0);
        chk("rst_cmd_ready", if0.cmd_ready, 1);
        chk("rst_sched_busy", sched_busy0, 0);
        chk("rst_sram_rd", if0.sram_rd_addr, 12'h5A5);
        chk("rst_sram_wr", if0.sram_wr_addr, 12'h3C3);
        chk("rst_wmem", if0.wmem_rd_addr, 12'h0F0);
        release_reset();

        for (int i = 0; i < 4; i++) begin
            fix_rd = vt[i].rd; fix_wr = vt[i].wr; fix_wm = vt[i].wm;
            push(vt[i].in_b, vt[i].out_b, vt[i].wgt_b);
            @(negedge clk); chk("lat_e0_run", if0.eng_run, 0);
            @(negedge clk); chk("lat_e1_run", if0.eng_run, 0);
            @(negedge clk); chk("lat_e2_run", if0.eng_run, 1);
            @(negedge clk); chk("lat_e3_run", if0.eng_run, 0);
            wait_busy();
            @(negedge clk);
            chk("vec_sram_rd", if0.sram_rd_addr, vt[i].e_rd);
            chk("vec_sram_wr", if0.sram_wr_addr, vt[i].e_wr);
            chk("vec_wmem", if0.wmem_rd_addr, vt[i].e_wm);
            wait_done();
            chk("vec_hold_rd", if0.sram_rd_addr, vt[i].e_rd);
            chk("vec_jobs", jobs0, i + 1);
        end
        wait_idle(200);
        check_counts("table");

        eng_stall = 1;
        push(12'h111, 12'h222, 12'h333);
        push(12'h444, 12'h555, 12'h666);
        push(12'h777, 12'h888, 12'h999);
        wait_busy();
        @(negedge clk);
        chk("pre_rst_busy", sched_busy0, 1);
        do_reset();
        #1;
        chk("mid_rst_eng_run", if0.eng_run, 0);
        chk("mid_rst_cmd_ready", if0.cmd_ready, 1);
        chk("mid_rst_sched_busy", sched_busy0, 0);
        chk("mid_rst_jobs", jobs0, 0);
        chk("mid_rst_job_done", job_done0, 0);
        eng_stall = 0;
        release_reset();
        lv = launches;
        repeat (12) @(negedge clk);
        chk("post_rst_no_launch", launches, lv);
        chk("post_rst_idle", sched_busy0, 0);

        rand_addr = 1; eng_hold = 10; eng_stall = 1;
        push(12'h010, 12'h020, 12'h030);
        wait_busy();
        for (int k = 1; k <= 4; k++) push(AW'(k * 12'h100), AW'(k * 12'h101), AW'(k * 12'h011));
        @(negedge clk);
        chk("full_ready", if0.cmd_ready, 0);
        chk("full_busy", sched_busy0, 1);
        cmd_valid = 1'b1; cin = 12'hA00; cout = 12'hB00; cwgt = 12'hC00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); chk("full_hold_ready", if0.cmd_ready, 0);
        end
        eng_stall = 0;
        push(12'hA00, 12'hB00, 12'hC00);
        wait_idle(2000);
        check_counts("fifo");
        chk("fifo_launches_drained", exp_q.size(), 0);

        eng_never = 1;
        push(12'h0AA, 12'h0BB, 12'h0CC);
        push(12'h1AA, 12'h1BB, 12'h1CC);
        wait_run();
        repeat (7) @(negedge clk);
        chk("to_err_before", start_err0, 0);
        @(negedge clk);
        chk("to_err_set", start_err0, 1);
        chk("to_no_done", job_done0, 0);
        eng_never = 0;
        wait_done();
        chk("to_err_sticky", start_err0, 1);
        wait_idle(300);
        check_counts("timeout");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        chk("to_err_clr", start_err0, 0);

        eng_never = 1; err_clr = 1'b1;
        push(12'h2AA, 12'h2BB, 12'h2CC);
        wait_run();
        repeat (7) @(negedge clk);
        chk("col_err_before", start_err0, 0);
        @(negedge clk);
        chk("col_set_wins", start_err0, 1);
        @(negedge clk);
        chk("col_clr_after", start_err0, 0);
        err_clr = 1'b0; eng_never = 0;

        rand_eng = 1;
        for (int n = 0; n < 24; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(AW'($urandom), AW'($urandom), AW'($urandom));
        end
        wait_idle(3000);
        check_counts("random");
        chk("rand_ready", if0.cmd_ready, 1);
        chk("rand_idle", sched_busy0, 0);
        chk("rand_err_clear", start_err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_job_scheduler.md
Name: conv_job_scheduler

Overview:
- Sequences a queue of XNOR-convolution jobs onto the single conv engine (dut_run/dut_busy handshake).
- Each job carries an input base, an output base and a weight base. The scheduler relocates the engine's local SRAM/WMEM addresses by those bases, so successive images and weight sets can be packed in the shared memories.
- Sits between the host/test harness and the conv engine. It owns dut_run and the SRAM/WMEM address buses seen by the memories.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
- ADDR_W, 12, SRAM/WMEM address width
- START_TIMEOUT, 8, cycles allowed after eng_run for eng_busy to rise
- CNT_W, 8, width of completed-job counter

Ports:
- clk  in  1  clock
- reset_b  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  FIFO can accept a command
- cmd_in_base  in  ADDR_W  input-image base address
- cmd_out_base  in  ADDR_W  output-image base address
- cmd_wgt_base  in  ADDR_W  weight base address
- eng_run  out  1  one-cycle start pulse to the engine
- eng_busy  in  1  engine busy
- eng_rd_addr  in  ADDR_W  engine-local input read address
- eng_wr_addr  in  ADDR_W  engine-local output write address
- eng_wmem_addr  in  ADDR_W  engine-local weight address
- sram_rd_addr  out  ADDR_W  relocated read address
- sram_wr_addr  out  ADDR_W  relocated write address
- wmem_rd_addr  out  ADDR_W  relocated weight address
- job_done  out  1  one-cycle pulse per completed job
- jobs_completed  out  CNT_W  saturating completed-job count
- start_err  out  1  sticky: engine failed to start in time
- err_clr  in  1  clears start_err
- sched_busy  out  1  FIFO non-empty or FSM not in IDLE

Behaviour:
- Single clock clk. Reset is asynchronous, active-low on reset_b.
- Reset values:
  - eng_run=0, job_done=0, jobs_completed=0, start_err=0.
  - FIFO empty, so cmd_ready=1.
  - FSM in IDLE; active base registers = 0.
  - Relocated address outputs equal the engine addresses (bases are 0).
- Reset mid-job aborts immediately. Queued commands are discarded; the engine is not notified.
- Command FIFO:
  - Push when cmd_valid & cmd_ready. cmd_ready = !full.
  - When full, cmd_ready stays 0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_START, RUN, DONE.
  - IDLE: if FIFO non-empty, pop the head into the active registers {in_base, out_base, wgt_base} and go to LAUNCH.
  - LAUNCH: eng_run=1 for exactly this cycle (registered output); clear the timer; go to WAIT_START.
  - WAIT_START:
    - If eng_busy=1, go to RUN.
    - Otherwise increment the timer. When the timer reaches START_TIMEOUT-1 with eng_busy still 0, set start_err, drop the job and go to IDLE. No job_done, no count change.
  - RUN: stay while eng_busy=1. On eng_busy=0, go to DONE.
  - DONE: job_done=1 for one cycle; jobs_completed increments, saturating at all-ones; go to IDLE.
- Latency: a command accepted at edge E0 into an empty FIFO with the FSM idle is popped at edge E1. eng_run is high from E2 to E3.
- Back-to-back jobs: minimum gap of 2 cycles from the job_done cycle to the next eng_run cycle (DONE -> IDLE -> LAUNCH).
- Relocation:
  - sram_rd_addr = active in_base + eng_rd_addr.
  - sram_wr_addr = active out_base + eng_wr_addr.
  - wmem_rd_addr = active wgt_base + eng_wmem_addr.
  - Combinational, modulo 2^ADDR_W (wrap-around, no carry-out).
  - Active bases change only on pop and hold through DONE and the following IDLE.
- start_err is sticky. err_clr clears it; if a timeout and err_clr occur in the same cycle, the set wins.
- sched_busy = (state != IDLE) | FIFO non-empty.

Test Plan:
- Single job: push {in 0x100, out 0x200, wgt 0x010}; engine model raises busy 2 cycles after eng_run and holds it 40 cycles. Required: eng_run exactly 1 cycle, 2 cycles after acceptance; eng_rd_addr 5 -> sram_rd_addr 0x105; eng_wmem_addr 1 -> wmem_rd_addr 0x011; one job_done; jobs_completed=1.
- FIFO full: push 5 commands back-to-back while the engine is stalled busy. Required: cmd_ready=0 after 4 pushes; 5th accepted only after a pop; all 5 jobs run in order; jobs_completed=5.
- Start timeout: engine never raises busy. Required: start_err=1 at the 8th WAIT_START cycle; no job_done; next queued job still launches. err_clr -> start_err=0.
- Wrap-around: in_base 0xFF0, eng_rd_addr 0x020. Required: sram_rd_addr 0x010.
- Reset mid-RUN with 2 jobs queued: assert reset_b=0. Required: immediately eng_run=0, cmd_ready=1, sched_busy=0, jobs_completed=0; after release no launch until a new push.
- Counter saturation: CNT_W=2, run 5 jobs. Required: jobs_completed sticks at 3; job_done still pulses 5 times.
